// File: rtl/stack_arbiter.sv
// Two-client round-robin front end for a shared 4-entry LIFO stack.
// Illegal ops (push when full, pop when empty) are refused without touching the stack.
module stack_arbiter #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ERR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0,
    input  logic                     pop0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic                     push1,
    input  logic                     pop1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     done0,
    output logic                     done1,
    output logic                     reject0,
    output logic                     reject1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [DATA_WIDTH-1:0]    stk_wdata,
    input  logic                     stk_empty,
    input  logic                     stk_full,
    input  logic [DATA_WIDTH-1:0]    stk_rdata,
    input  logic                     stk_error,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     gid_q, gid_d;
    logic                     op_push_q, op_push_d;
    logic                     rej_q, rej_d;
    logic                     done0_q, done0_d, done1_q, done1_d;
    logic                     reject0_q, reject0_d, reject1_q, reject1_d;
    logic                     stk_push_q, stk_push_d, stk_pop_q, stk_pop_d;
    logic [DATA_WIDTH-1:0]    stk_wdata_q, stk_wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_sticky_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;

    logic                     req0, req1, pick, pick_push, illegal, pop_cap;
    logic [DATA_WIDTH-1:0]    pick_wdata;

    // Popped data is only valid from the stack during RESP, so it is forwarded that cycle
    assign pop_cap = (state_q == S_RESP) && !rej_q && !op_push_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            gid_q        <= 1'b0;
            op_push_q    <= 1'b0;
            rej_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            reject0_q    <= 1'b0;
            reject1_q    <= 1'b0;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            stk_wdata_q  <= '0;
            rdata_q      <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gid_q       <= gid_d;
            op_push_q   <= op_push_d;
            rej_q       <= rej_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            reject0_q   <= reject0_d;
            reject1_q   <= reject1_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            stk_wdata_q <= stk_wdata_d;
            if (pop_cap) begin
                rdata_q <= stk_rdata;
            end
            if (stk_error) begin
                err_sticky_q <= 1'b1;
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Grant selection and next-state / registered-output decode
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gid_d       = gid_q;
        op_push_d   = op_push_q;
        rej_d       = rej_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        reject0_d   = 1'b0;
        reject1_d   = 1'b0;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_wdata_d = '0;

        req0       = push0 | pop0;
        req1       = push1 | pop1;
        pick       = (req0 && req1) ? ~last_q : req1;
        pick_push  = pick ? push1 : push0;
        pick_wdata = pick ? wdata1 : wdata0;
        illegal    = pick_push ? stk_full : stk_empty;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gid_d     = pick;
                    last_d    = pick;
                    op_push_d = pick_push;
                    rej_d     = illegal;
                    if (illegal) begin
                        state_d   = S_RESP;
                        reject0_d = ~pick;
                        reject1_d = pick;
                    end else begin
                        state_d     = S_ISSUE;
                        stk_push_d  = pick_push;
                        stk_pop_d   = ~pick_push;
                        stk_wdata_d = pick_push ? pick_wdata : '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
                done0_d = ~gid_q & ~rej_q;
                done1_d = gid_q & ~rej_q;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done0      = done0_q;
    assign done1      = done1_q;
    assign reject0    = reject0_q;
    assign reject1    = reject1_q;
    assign stk_push   = stk_push_q;
    assign stk_pop    = stk_pop_q;
    assign stk_wdata  = stk_wdata_q;
    assign rdata      = pop_cap ? stk_rdata : rdata_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural LIFO environment plus a transaction-schedule reference model.
module tb_stack_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push0, pop0, push1, pop1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1, reject0, reject1;
    logic [DW-1:0] rdata;
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_wdata;
    logic          stk_empty, stk_full;
    logic [DW-1:0] stk_rdata = '0;
    logic          stk_error;
    logic          err_sticky;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .push0(push0), .pop0(pop0), .wdata0(wdata0),
        .push1(push1), .pop1(pop1), .wdata1(wdata1),
        .done0(done0), .done1(done1), .reject0(reject0), .reject1(reject1),
        .rdata(rdata),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_empty(stk_empty), .stk_full(stk_full), .stk_rdata(stk_rdata),
        .stk_error(stk_error),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    // Stack environment: 4-deep LIFO, read data registered on pop
    logic [DW-1:0] env_q[$];
    int            env_n     = 0;
    logic          env_err_q = 1'b0;
    logic          force_err = 1'b0;
    assign stk_empty = (env_n == 0);
    assign stk_full  = (env_n == 4);
    assign stk_error = env_err_q | force_err;

    always @(posedge clk) begin : env_stack
        bit e;
        e = 1'b0;
        if (stk_push && stk_pop) e = 1'b1;
        if (stk_push) begin
            if (env_q.size() == 4) e = 1'b1;
            else env_q.push_back(stk_wdata);
        end
        if (stk_pop) begin
            if (env_q.size() == 0) e = 1'b1;
            else stk_rdata <= env_q.pop_back();
        end
        env_err_q <= e;
        env_n     <= env_q.size();
    end

    logic smp_err = 1'b0;
    always @(posedge clk) smp_err = stk_error;

    // Reference model state
    int            n_chk = 0, n_fail = 0;
    int            edge_no = 0, free_at = 0, pend_edge = 0;
    bit            m_last = 1'b1, pend = 1'b0, pend_id, pend_push;
    logic [DW-1:0] pend_val, exp_rdata = '0, exp_wd;
    logic [DW-1:0] ref_stk[$];
    logic [DW-1:0] obs_pops[$];
    int            exp_cnt = 0;
    bit            exp_sticky = 1'b0, exp_push, exp_pop;
    bit [1:0]      exp_done, exp_rej;
    int            n_rej_obs[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp_v, edge_no);
        end
    endtask

    task automatic set_req(input int c, input bit p, input bit q, input logic [DW-1:0] d);
        if (c == 0) begin push0 = p; pop0 = q; wdata0 = d; end
        else        begin push1 = p; pop1 = q; wdata1 = d; end
    endtask

    function automatic bit any_req();
        return push0 | pop0 | push1 | pop1;
    endfunction

    // Advance one clock: predict what the edge just passed produced, compare, retire finished requests
    task automatic tick();
        bit r0, r1, g, op_push, pop_done;
        @(negedge clk);
        edge_no++;
        exp_done = '0; exp_rej = '0; exp_push = 1'b0; exp_pop = 1'b0; exp_wd = '0;
        pop_done = 1'b0;
        if (rst) begin
            m_last = 1'b1; pend = 1'b0; free_at = edge_no + 1;
            exp_rdata = '0; exp_cnt = 0; exp_sticky = 1'b0;
        end else begin
            if (smp_err) begin
                exp_sticky = 1'b1;
                if (exp_cnt < 15) exp_cnt++;
            end
            if (pend && pend_edge == edge_no - 1) begin
                exp_done[pend_id] = 1'b1;
                if (!pend_push) begin exp_rdata = pend_val; pop_done = 1'b1; end
                pend = 1'b0;
            end
            r0 = push0 | pop0;
            r1 = push1 | pop1;
            if (edge_no >= free_at && (r0 || r1)) begin
                g = (r0 && r1) ? !m_last : r1;
                m_last  = g;
                op_push = g ? push1 : push0;
                if (op_push ? (ref_stk.size() == 4) : (ref_stk.size() == 0)) begin
                    exp_rej[g] = 1'b1;
                    free_at = edge_no + 2;
                end else begin
                    if (op_push) begin
                        exp_push = 1'b1;
                        exp_wd   = g ? wdata1 : wdata0;
                        ref_stk.push_back(exp_wd);
                    end else begin
                        exp_pop  = 1'b1;
                        pend_val = ref_stk.pop_back();
                    end
                    pend = 1'b1; pend_id = g; pend_push = op_push; pend_edge = edge_no;
                    free_at = edge_no + 3;
                end
            end
        end
        chk("done0", 32'(done0), 32'(exp_done[0]));
        chk("done1", 32'(done1), 32'(exp_done[1]));
        chk("reject0", 32'(reject0), 32'(exp_rej[0]));
        chk("reject1", 32'(reject1), 32'(exp_rej[1]));
        chk("stk_push", 32'(stk_push), 32'(exp_push));
        chk("stk_pop", 32'(stk_pop), 32'(exp_pop));
        chk("stk_wdata", 32'(stk_wdata), 32'(exp_wd));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        if (pop_done) obs_pops.push_back(rdata);
        if (reject0) n_rej_obs[0]++;
        if (reject1) n_rej_obs[1]++;
        for (int c = 0; c < 2; c++) begin
            if (rst || exp_done[c] || exp_rej[c]) set_req(c, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((any_req() || pend || edge_no + 1 < free_at) && n < budget) begin
            tick();
            n++;
        end
        if (any_req() || pend || edge_no + 1 < free_at) begin
            chk("idle_timeout", 32'(n), 32'(budget + 1));
            set_req(0, 1'b0, 1'b0, '0);
            set_req(1, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic do_op(input int c, input bit p, input bit q, input logic [DW-1:0] d);
        set_req(c, p, q, d);
        run_until_idle(40);
    endtask

    initial begin
        int rej_before;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, '0);
        repeat (2) tick();
        rst = 1'b0;

        // Single push from client 0
        do_op(0, 1'b1, 1'b0, 8'h11);

        // Simultaneous pushes right after reset: client 0 first
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'hA0);
        set_req(1, 1'b1, 1'b0, 8'hB0);
        run_until_idle(40);
        chk("t2_order0", 32'(env_q[env_q.size()-2]), 32'h0A0);
        chk("t2_order1", 32'(env_q[env_q.size()-1]), 32'h0B0);

        // Fill, then push to a full stack
        do_op(0, 1'b1, 1'b0, 8'h33);
        chk("t3_full_before", 32'(stk_full), 32'd1);
        rej_before = n_rej_obs[1];
        do_op(1, 1'b1, 1'b0, 8'h55);
        chk("t3_reject1", 32'(n_rej_obs[1] - rej_before), 32'd1);
        chk("t3_full_after", 32'(stk_full), 32'd1);

        // Drain, load 0x01..0x04, pop twice from client 1
        repeat (4) do_op(0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 4; i++) do_op(0, 1'b1, 1'b0, DW'(i));
        obs_pops.delete();
        do_op(1, 1'b0, 1'b1, '0);
        do_op(1, 1'b0, 1'b1, '0);
        chk("t4_pop_first", 32'(obs_pops[0]), 32'h04);
        chk("t4_pop_second", 32'(obs_pops[1]), 32'h03);

        // Pop from an empty stack
        repeat (2) do_op(0, 1'b0, 1'b1, '0);
        rej_before = n_rej_obs[0];
        do_op(0, 1'b0, 1'b1, '0);
        chk("t5_reject0", 32'(n_rej_obs[0] - rej_before), 32'd1);
        chk("t5_rdata_held", 32'(rdata), 32'h01);

        // Error counter saturation and clear
        force_err = 1'b1;
        repeat (20) tick();
        force_err = 1'b0;
        tick();
        chk("t6_sticky", 32'(err_sticky), 32'd1);
        chk("t6_count_sat", 32'(err_count), 32'hF);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_sticky_clr", 32'(err_sticky), 32'd0);
        chk("t6_count_clr", 32'(err_count), 32'd0);

        // Reset while an op is in flight discards its done pulse
        set_req(0, 1'b1, 1'b0, 8'h77);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t7_no_done", 32'(done0), 32'd0);
        run_until_idle(10);

        // Randomised traffic
        for (int it = 0; it < 1500; it++) begin
            for (int c = 0; c < 2; c++) begin
                bit busy;
                int kind;
                busy = (c == 0) ? (push0 | pop0) : (push1 | pop1);
                if (!busy && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 2);
                    set_req(c, kind != 1, kind != 0, DW'($urandom));
                end
            end
            force_err = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        force_err = 1'b0;
        run_until_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
